myproject_udiv_14ns_6ns_9_seq: RTL and testbench
================================================

// Module: myproject_udiv_14ns_6ns_9_seq
// PURPOSE
//  Sequential unsigned restoring divider; inverse of the 9ns x 6ns -> 14 multiplier cores.
//  Divides a 14-bit unsigned dividend by a 6-bit unsigned divisor, one quotient bit per cycle.
//  Used in normalisation/rescale paths where a product must be mapped back to the
//  pre-multiply domain without a full combinational divider.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  din0_WIDTH  14  dividend width (unsigned)
//  din1_WIDTH  6   divisor width (unsigned)
//  dout_WIDTH  9   quotient output width; full quotient is din0_WIDTH bits, then saturated
// PORTS
//  ap_clk     in   1            clock, all logic on rising edge
//  ap_rst     in   1            reset, asynchronous, active-high
//  start      in   1            request; sampled only in IDLE
//  din0       in   din0_WIDTH   dividend, captured on accepted start
//  din1       in   din1_WIDTH   divisor, captured on accepted start
//  busy       out  1            high from the cycle after accept until done cycle inclusive
//  done       out  1            single-cycle pulse, results valid
//  dout       out  dout_WIDTH   quotient (saturated), held until next accepted start
//  ovf        out  1            quotient exceeded 2^dout_WIDTH-1 or divisor was zero
//  rem        out  din1_WIDTH   remainder (only with MYPROJECT_UDIV_REM_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, ovf = 0; dout = 0; rem = 0; internal regs cleared.
//  - FSM IDLE -> RUN on start=1 (captures din0, din1; cnt = din0_WIDTH-1; partial rem = 0).
//  - RUN: each cycle rem' = {rem, dividend[cnt]}; if rem' >= divisor then subtract, q[cnt]=1.
//    Partial remainder is din1_WIDTH+1 bits wide. cnt decrements; at cnt==0 -> DONE.
//  - DONE: one cycle; done=1, dout/ovf/rem registered; -> IDLE next cycle.
//  - Latency: accept at cycle T -> done at T+din0_WIDTH+1 (15 cycles default). Throughput
//    one op per din0_WIDTH+2 cycles; start may be held high for back-to-back ops.
//  - start while busy (RUN or DONE): ignored, no queueing; inputs not re-captured.
//  - Overflow: full quotient > 2^dout_WIDTH-1 -> dout = all-ones, ovf=1.
//  - Divisor zero: detected at accept; still runs full latency; dout = all-ones, ovf=1,
//    rem = 0.
//  - Outputs dout/ovf/rem change only in the DONE cycle; stable otherwise.
//  - ap_rst asserted mid-operation: immediate abort to reset state; no done pulse.
// CONFIGURATION
//  MYPROJECT_UDIV_REM_EN defined: rem port present, carries final remainder
//    (< divisor, exact for non-zero divisor).
//  Not defined: rem port and remainder output register absent; the partial-remainder
//    datapath is unchanged; dout/ovf behaviour identical.
// STRUCTURE
//  Package myproject_udiv_pkg: state enum {IDLE, RUN, DONE}; localparams for default
//    widths and CNT_W = $clog2(din0_WIDTH).
//  Sub-module myproject_udiv_step: combinational single restoring step
//    (rem_in, bit_in, divisor) -> (rem_out, q_bit); instantiated once, reused each cycle.
//  Top holds FSM, counter, shift regs, saturation and output registers.
// TESTING
//  1. din0=9000, din1=45, start 1 cycle -> done at +15 cycles, dout=200, ovf=0, rem=0.
//  2. din0=13000, din1=7 -> full q=1857 > 511: dout=511, ovf=1, rem=1.
//  3. din0=1234, din1=0 -> done at +15, dout=511, ovf=1, rem=0.
//  4. accept 100/3, pulse start with 50/5 at +5 -> only done for dout=33, rem=1; no 2nd done.
//  5. accept 9000/45, assert ap_rst at +7 -> busy/done/dout/ovf=0 at once; no done later.
//  6. start held high, alternating 16383/63, 0/1 -> done pulses every 16 cycles;
//     dout=260,ovf=0,rem=3 then dout=0,ovf=0,rem=0; build run with and without
//     MYPROJECT_UDIV_REM_EN.

Source files
------------

// File: rtl/myproject_udiv_pkg.sv
// rtl/myproject_udiv_pkg.sv - shared types and default widths for the sequential unsigned divider
package myproject_udiv_pkg;

    localparam int DIN0_W = 14;
    localparam int DIN1_W = 6;
    localparam int DOUT_W = 9;

    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_bits(DIN0_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } udiv_state_e;

endpackage

// File: rtl/myproject_udiv_step.sv
// rtl/myproject_udiv_step.sv - one combinational restoring-division step
module myproject_udiv_step
    import myproject_udiv_pkg::*;
#(
    parameter int W = DIN1_W
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_bit_o = (shifted >= {1'b0, divisor_i});
        // A true difference is below the divisor, so W-bit wraparound arithmetic is exact
        rem_o   = q_bit_o ? (shifted[W-1:0] - divisor_i) : shifted[W-1:0];
    end

endmodule

// File: rtl/myproject_udiv_14ns_6ns_9_seq.sv
// rtl/myproject_udiv_14ns_6ns_9_seq.sv - sequential restoring divider, saturated quotient; MYPROJECT_UDIV_REM_EN adds rem port
module myproject_udiv_14ns_6ns_9_seq
    import myproject_udiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
`ifdef MYPROJECT_UDIV_REM_EN
    ,
    output logic [din1_WIDTH-1:0] rem
`endif
);

    localparam int CW = cnt_bits(din0_WIDTH);

    udiv_state_e             state_q, state_d;
    logic [din0_WIDTH-1:0]   dividend_q;
    logic [din1_WIDTH-1:0]   divisor_q;
    logic [din1_WIDTH-1:0]   prem_q;
    logic [din0_WIDTH-2:0]   q_q;
    logic [CW-1:0]           cnt_q;
    logic                    dz_q;
    logic [dout_WIDTH-1:0]   dout_q;
    logic                    ovf_q;

    logic                    accept;
    logic                    last_step;
    logic [din1_WIDTH-1:0]   step_rem;
    logic                    step_q;
    logic [din0_WIDTH-1:0]   q_full;
    logic                    sat;

    myproject_udiv_step #(.W(din1_WIDTH)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dividend_q[cnt_q]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == RUN) && (cnt_q == '0);
    assign q_full    = {q_q, step_q};
    // Zero divisor already yields an all-ones quotient, but the flag keeps ovf explicit
    assign sat       = dz_q || (|q_full[din0_WIDTH-1:dout_WIDTH]);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            prem_q     <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            dz_q       <= 1'b0;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            dividend_q <= din0;
            divisor_q  <= din1;
            dz_q       <= (din1 == '0);
            prem_q     <= '0;
            q_q        <= '0;
            cnt_q      <= CW'(din0_WIDTH - 1);
        end else if (state_q == RUN) begin
            prem_q <= step_rem;
            q_q    <= {q_q[din0_WIDTH-3:0], step_q};
            cnt_q  <= cnt_q - 1'b1;
            if (last_step) begin
                dout_q <= sat ? '1 : q_full[dout_WIDTH-1:0];
                ovf_q  <= sat;
            end
        end
    end

    assign dout = dout_q;
    assign ovf  = ovf_q;

`ifdef MYPROJECT_UDIV_REM_EN
    logic [din1_WIDTH-1:0] rem_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rem_q <= '0;
        end else if (last_step) begin
            rem_q <= dz_q ? '0 : step_rem;
        end
    end

    assign rem = rem_q;
`endif

endmodule

// File: tb/tb_myproject_udiv_14ns_6ns_9_seq.sv
// tb/tb_myproject_udiv_14ns_6ns_9_seq.sv - directed self-checking bench for the sequential divider
module tb_myproject_udiv_14ns_6ns_9_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        start  = 1'b0;
    logic [13:0] din0   = '0;
    logic [5:0]  din1   = '0;
    logic        busy;
    logic        done;
    logic [8:0]  dout;
    logic        ovf;
`ifdef MYPROJECT_UDIV_REM_EN
    logic [5:0]  rem;
`endif

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    myproject_udiv_14ns_6ns_9_seq #(
        .ID         (1),
        .din0_WIDTH (14),
        .din1_WIDTH (6),
        .dout_WIDTH (9)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .start  (start),
        .din0   (din0),
        .din1   (din1),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .ovf    (ovf)
`ifdef MYPROJECT_UDIV_REM_EN
        ,
        .rem    (rem)
`endif
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One start pulse; optional second start pulse at cycle 'poke' that must be ignored
    task automatic run_op(input string tag, input int a, input int b,
                          input int eq, input int eovf, input int erem, input int poke);
        int         lat    = 0;
        int         ndone  = 0;
        bit         stable = 1'b1;
        logic [8:0] held_d;
        logic       held_o;
        logic [8:0] got_d  = '0;
        logic       got_o  = 1'b0;
        logic [5:0] got_r  = '0;
        @(negedge ap_clk);
        din0   = 14'(a);
        din1   = 6'(b);
        start  = 1'b1;
        held_d = dout;
        held_o = ovf;
        for (int n = 1; n <= 32; n++) begin
            @(negedge ap_clk);
            start = 1'b0;
            if (n == poke) begin
                din0  = 14'd50;
                din1  = 6'd5;
                start = 1'b1;
            end
            if (n == 1) chk({tag, ".busy"}, busy, 1);
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
                got_d  = dout;
                got_o  = ovf;
`ifdef MYPROJECT_UDIV_REM_EN
                got_r  = rem;
`endif
                held_d = dout;
                held_o = ovf;
            end else if (dout !== held_d || ovf !== held_o) begin
                stable = 1'b0;
            end
        end
        chk({tag, ".lat"}, lat, 15);
        chk({tag, ".ndone"}, ndone, 1);
        chk({tag, ".dout"}, got_d, eq);
        chk({tag, ".ovf"}, got_o, eovf);
`ifdef MYPROJECT_UDIV_REM_EN
        chk({tag, ".rem"}, got_r, erem);
`else
        chk({tag, ".rem_absent"}, got_r, 0);
        if (erem < 0) chk({tag, ".erem"}, erem, 0);
`endif
        chk({tag, ".stable"}, stable, 1);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        int k;
        int cyc;
        int last;
        int nd;

        repeat (3) @(negedge ap_clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.dout", dout, 0);
        chk("rst.ovf", ovf, 0);
        ap_rst = 1'b0;

        run_op("t1", 9000, 45, 200, 0, 0, 0);
        run_op("t2", 13000, 7, 511, 1, 1, 0);

        // Abort mid-run: outputs clear asynchronously, no done afterwards
        @(negedge ap_clk);
        din0  = 14'd9000;
        din1  = 6'd45;
        start = 1'b1;
        repeat (7) begin
            @(negedge ap_clk);
            start = 1'b0;
        end
        ap_rst = 1'b1;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.dout", dout, 0);
        chk("abort.ovf", ovf, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge ap_clk);
            if (done) nd++;
        end
        chk("abort.nodone", nd, 0);

        run_op("t3", 1234, 0, 511, 1, 0, 0);
        run_op("t4", 100, 3, 33, 0, 1, 5);
        run_op("edge511", 16352, 32, 511, 0, 0, 0);
        run_op("edge512", 3584, 7, 511, 1, 0, 0);

        // start held high: accepts back-to-back every 16 cycles
        @(negedge ap_clk);
        din0  = 14'd16383;
        din1  = 6'd63;
        start = 1'b1;
        k     = 0;
        cyc   = 0;
        last  = 0;
        while (k < 4 && cyc < 100) begin
            @(negedge ap_clk);
            cyc++;
            if (done) begin
                chk("b2b.gap", cyc - last, (k == 0) ? 15 : 16);
                last = cyc;
                if ((k % 2) == 0) begin
                    chk("b2b.dout_a", dout, 260);
                    chk("b2b.ovf_a", ovf, 0);
`ifdef MYPROJECT_UDIV_REM_EN
                    chk("b2b.rem_a", rem, 3);
`endif
                    din0 = 14'd0;
                    din1 = 6'd1;
                end else begin
                    chk("b2b.dout_b", dout, 0);
                    chk("b2b.ovf_b", ovf, 0);
`ifdef MYPROJECT_UDIV_REM_EN
                    chk("b2b.rem_b", rem, 0);
`endif
                    din0 = 14'd16383;
                    din1 = 6'd63;
                end
                k++;
            end
        end
        start = 1'b0;
        chk("b2b.count", k, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
